// File: rtl/store_if.sv
// Store unit <-> data memory bus.
// The memory is word-wide, single-port, with synchronous read and write.
interface store_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              mem_rw_mode;  // 0 read, 1 write
    logic [ADDR_W-1:0] mem_addr;     // word address
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_data;     // read data, valid the cycle after the address

    modport master (
        output mem_rw_mode,
        output mem_addr,
        output mem_wdata,
        input  mem_data
    );

    modport slave (
        input  mem_rw_mode,
        input  mem_addr,
        input  mem_wdata,
        output mem_data
    );
endinterface

// File: rtl/store.sv
// RISC-V store unit: SW is a direct single-cycle write; SB/SH use a two-cycle
// read-modify-write because the data memory has no byte enables.
// Optional macro STORE_MISALIGN_TRAP_EN adds misalign_fault and suppresses
// misaligned SH/SW instead of truncating their addresses.
module store #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    input  logic [1:0]  store_control,
    output logic        stall_pc,
    output logic        stall_other_exec,
    output logic        busy,
`ifdef STORE_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    store_if.master     mem
);

    localparam logic [1:0] CtrlNop = 2'b00;
    localparam logic [1:0] CtrlSb  = 2'b01;
    localparam logic [1:0] CtrlSh  = 2'b10;
    localparam logic [1:0] CtrlSw  = 2'b11;

    typedef enum logic [0:0] {StIdle, StMerge} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [1:0]        lsb_q, lsb_d;

    logic [31:0]       eff_addr;
    logic [1:0]        lsb;
    logic [ADDR_W-1:0] word_addr;
    logic              misaligned;
    logic              rw_mode;
    logic [ADDR_W-1:0] addr_out;
    logic [31:0]       wdata_out;
    logic [31:0]       merged;
    logic              unused_addr;

    assign eff_addr    = rs1_val + imm;
    assign lsb         = eff_addr[1:0];
    assign word_addr   = eff_addr[ADDR_W+1:2];
    assign unused_addr = ^eff_addr[31:ADDR_W+2];

`ifdef STORE_MISALIGN_TRAP_EN
    assign misaligned = ((store_control == CtrlSh) && lsb[0]) ||
                        ((store_control == CtrlSw) && (lsb != 2'b00));
    assign misalign_fault = (state_q == StIdle) && misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // Replace the selected lane of the word read during the issue cycle.
    always_comb begin
        merged = mem.mem_data;
        if (ctrl_q == CtrlSb) begin
            case (lsb_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (ctrl_q == CtrlSh) begin
            if (lsb_q[1]) merged[31:16] = data_q;
            else          merged[15:0]  = data_q;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        ctrl_d           = ctrl_q;
        lsb_d            = lsb_q;
        stall_pc         = 1'b0;
        stall_other_exec = 1'b0;
        busy             = 1'b0;
        rw_mode          = 1'b0;
        addr_out         = '0;
        wdata_out        = '0;
        unique case (state_q)
            StIdle: begin
                // A trapped store issues nothing and never reaches memory.
                if (!misaligned) begin
                    case (store_control)
                        CtrlSw: begin
                            rw_mode   = 1'b1;
                            addr_out  = word_addr;
                            wdata_out = rs2_val;
                        end
                        CtrlSb, CtrlSh: begin
                            addr_out = word_addr;
                            stall_pc = 1'b1;
                            addr_d   = word_addr;
                            data_d   = rs2_val[15:0];
                            ctrl_d   = store_control;
                            lsb_d    = lsb;
                            state_d  = StMerge;
                        end
                        default: ;
                    endcase
                end
            end
            StMerge: begin
                rw_mode          = 1'b1;
                addr_out         = addr_q;
                wdata_out        = merged;
                stall_other_exec = 1'b1;
                busy             = 1'b1;
                ctrl_d           = CtrlNop;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured RMW fields; async reset drops any pending store.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            ctrl_q  <= CtrlNop;
            lsb_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            lsb_q   <= lsb_d;
        end
    end

    assign mem.mem_rw_mode = rw_mode;
    assign mem.mem_addr    = addr_out;
    assign mem.mem_wdata   = wdata_out;

endmodule

// File: tb/tb_store.sv
// Directed bench for the store unit with a behavioural synchronous memory.
module tb_store;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [1:0]  store_control;
    logic        stall_pc, stall_other_exec, busy;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    store_if #(.ADDR_W(10)) bus ();

    store #(.ADDR_W(10)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .imm              (imm),
        .store_control    (store_control),
        .stall_pc         (stall_pc),
        .stall_other_exec (stall_other_exec),
        .busy             (busy),
`ifdef STORE_MISALIGN_TRAP_EN
        .misalign_fault   (misalign_fault),
`endif
        .mem              (bus)
    );

    // Memory model with a bench-side preload port.
    logic [31:0] mem [1024];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          wr_cnt = 0;

    always @(posedge i_clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_rw_mode) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        bus.mem_data <= mem[bus.mem_addr];
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge i_clk);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge i_clk);
        pre_en   = 1'b0;
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] r1, input logic [31:0] im,
                         input logic [31:0] r2);
        store_control = c;
        rs1_val       = r1;
        imm           = im;
        rs2_val       = r2;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        #2;
        n_vec++; if (bus.mem_rw_mode !== 1'b0) begin n_bad++;
            $display("FAIL reset_rw got %b want 0", bus.mem_rw_mode); end
        n_vec++; if (bus.mem_addr !== 10'h0) begin n_bad++;
            $display("FAIL reset_addr got %h want 000", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 32'h0) begin n_bad++;
            $display("FAIL reset_wdata got %h want 0", bus.mem_wdata); end
        n_vec++; if ({stall_pc, stall_other_exec, busy} !== 3'b000) begin n_bad++;
            $display("FAIL reset_flags got %b want 000", {stall_pc, stall_other_exec, busy}); end
`ifdef STORE_MISALIGN_TRAP_EN
        n_vec++; if (misalign_fault !== 1'b0) begin n_bad++;
            $display("FAIL reset_fault got %b want 0", misalign_fault); end
`endif
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_sw;
        @(negedge i_clk);
        drive(2'b11, 32'h100, 32'h4, 32'hDEADBEEF);
        #1;
        n_vec++; if (bus.mem_rw_mode !== 1'b1) begin n_bad++;
            $display("FAIL sw_rw got %b want 1", bus.mem_rw_mode); end
        n_vec++; if (bus.mem_addr !== 10'h041) begin n_bad++;
            $display("FAIL sw_addr got %h want 041", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL sw_wdata got %h want deadbeef", bus.mem_wdata); end
        n_vec++; if ({stall_pc, busy} !== 2'b00) begin n_bad++;
            $display("FAIL sw_stall got %b want 00", {stall_pc, busy}); end
        @(negedge i_clk);
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        n_vec++; if (mem[10'h041] !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL sw_mem got %h want deadbeef", mem[10'h041]); end
    endtask

    // Issue at the current negedge, then check the merge cycle and the result.
    task automatic rmw(input string name, input logic [1:0] c, input logic [31:0] r1,
                       input logic [31:0] im, input logic [31:0] r2, input logic [9:0] wa,
                       input logic [31:0] expect_word);
        drive(c, r1, im, r2);
        #1;
        n_vec++; if ({stall_pc, bus.mem_rw_mode} !== 2'b10) begin n_bad++;
            $display("FAIL %s_issue stall_pc/rw got %b want 10", name, {stall_pc, bus.mem_rw_mode}); end
        n_vec++; if (bus.mem_addr !== wa) begin n_bad++;
            $display("FAIL %s_issue_addr got %h want %h", name, bus.mem_addr, wa); end
        @(negedge i_clk);
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        #1;
        n_vec++; if ({stall_other_exec, bus.mem_rw_mode, busy, stall_pc} !== 4'b1110) begin n_bad++;
            $display("FAIL %s_merge flags got %b want 1110", name,
                     {stall_other_exec, bus.mem_rw_mode, busy, stall_pc}); end
        n_vec++; if (bus.mem_wdata !== expect_word) begin n_bad++;
            $display("FAIL %s_wdata got %h want %h", name, bus.mem_wdata, expect_word); end
        @(negedge i_clk);
        n_vec++; if (mem[wa] !== expect_word) begin n_bad++;
            $display("FAIL %s_mem got %h want %h", name, mem[wa], expect_word); end
        n_vec++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL %s_idle busy got %b want 0", name, busy); end
    endtask

    task automatic test_sb_sweep;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h112233AB;
        exp_w[1] = 32'h1122AB44;
        exp_w[2] = 32'h11AB3344;
        exp_w[3] = 32'hAB223344;
        for (int i = 0; i < 4; i++) begin
            preload(10'h010, 32'h11223344);
            rmw($sformatf("sb%0d", i), 2'b01, 32'h40, i, 32'h000000AB, 10'h010, exp_w[i]);
        end
    endtask

    task automatic test_sh;
        preload(10'h010, 32'hCAFEF00D);
        rmw("sh_hi", 2'b10, 32'h42, 32'h0, 32'h00001234, 10'h010, 32'h1234F00D);
        preload(10'h010, 32'hCAFEF00D);
        rmw("sh_lo", 2'b10, 32'h44, 32'hFFFFFFFC, 32'hFFFF5678, 10'h010, 32'hCAFE5678);
    endtask

    task automatic test_back_to_back;
        int cnt0;
        preload(10'h010, 32'h11223344);
        cnt0 = wr_cnt;
        drive(2'b01, 32'h40, 32'h0, 32'hAB);
        @(negedge i_clk);
        drive(2'b11, 32'h200, 32'h0, 32'h55AA55AA);   // held through merge
        #1;
        n_vec++; if (bus.mem_addr !== 10'h010 || bus.mem_wdata !== 32'h112233AB) begin n_bad++;
            $display("FAIL b2b_merge got %h/%h want 010/112233ab", bus.mem_addr, bus.mem_wdata); end
        @(negedge i_clk);
        #1;
        n_vec++; if (bus.mem_rw_mode !== 1'b1 || bus.mem_addr !== 10'h080) begin n_bad++;
            $display("FAIL b2b_sw got rw %b addr %h want 1/080", bus.mem_rw_mode, bus.mem_addr); end
        @(negedge i_clk);
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        n_vec++; if (mem[10'h080] !== 32'h55AA55AA) begin n_bad++;
            $display("FAIL b2b_mem got %h want 55aa55aa", mem[10'h080]); end
        n_vec++; if (wr_cnt - cnt0 !== 2) begin n_bad++;
            $display("FAIL b2b_writes got %0d want 2", wr_cnt - cnt0); end
    endtask

    task automatic test_async_reset;
        int cnt0;
        preload(10'h010, 32'hCAFEF00D);
        cnt0 = wr_cnt;
        drive(2'b01, 32'h41, 32'h0, 32'h77);
        @(negedge i_clk);
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        #1;
        n_vec++; if (bus.mem_rw_mode !== 1'b1) begin n_bad++;
            $display("FAIL arst_pre rw got %b want 1", bus.mem_rw_mode); end
        i_rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.mem_rw_mode, busy, stall_other_exec} !== 3'b000) begin n_bad++;
            $display("FAIL arst_now got %b want 000", {bus.mem_rw_mode, busy, stall_other_exec}); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_vec++; if (mem[10'h010] !== 32'hCAFEF00D || wr_cnt !== cnt0) begin n_bad++;
            $display("FAIL arst_mem got %h writes %0d want cafef00d 0", mem[10'h010], wr_cnt - cnt0); end
        n_vec++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL arst_busy got %b want 0", busy); end
    endtask

    task automatic test_misalign;
        int cnt0;
        preload(10'h010, 32'h11223344);
        cnt0 = wr_cnt;
        drive(2'b11, 32'h40, 32'h1, 32'h0BADF00D);
        #1;
`ifdef STORE_MISALIGN_TRAP_EN
        n_vec++; if ({misalign_fault, bus.mem_rw_mode} !== 2'b10) begin n_bad++;
            $display("FAIL mis_fault got %b want 10", {misalign_fault, bus.mem_rw_mode}); end
        @(negedge i_clk);
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        #1;
        n_vec++; if ({misalign_fault, busy} !== 2'b00) begin n_bad++;
            $display("FAIL mis_after got %b want 00", {misalign_fault, busy}); end
        @(negedge i_clk);
        n_vec++; if (mem[10'h010] !== 32'h11223344 || wr_cnt !== cnt0) begin n_bad++;
            $display("FAIL mis_mem got %h writes %0d want 11223344 0", mem[10'h010], wr_cnt - cnt0); end
`else
        n_vec++; if (bus.mem_rw_mode !== 1'b1 || bus.mem_addr !== 10'h010) begin n_bad++;
            $display("FAIL mis_sw got rw %b addr %h want 1/010", bus.mem_rw_mode, bus.mem_addr); end
        @(negedge i_clk);
        drive(2'b00, 32'h0, 32'h0, 32'h0);
        n_vec++; if (mem[10'h010] !== 32'h0BADF00D || wr_cnt - cnt0 !== 1) begin n_bad++;
            $display("FAIL mis_mem got %h writes %0d want 0badf00d 1", mem[10'h010], wr_cnt - cnt0); end
`endif
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_sweep();
        test_sh();
        test_back_to_back();
        test_async_reset();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
